// File: rtl/alu_mul_seq.sv
// Sequential 8x8 unsigned shift-add multiplier that borrows an external registered ALU.
// Define ALU_MUL_SKIP_EN to bypass the ADD step for zero multiplier bits.
module alu_mul_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RDY,
    input  logic        start,
    input  logic [7:0]  a_in,
    input  logic [7:0]  b_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] prod,
    output logic [3:0]  alu_op,
    output logic        alu_right,
    output logic [7:0]  alu_ai,
    output logic [7:0]  alu_bi,
    output logic        alu_ci,
    output logic        alu_bcd,
    input  logic [7:0]  alu_out,
    input  logic        alu_co
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADD  = 3'd1,
        S_SHR  = 3'd2,
        S_CAP  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t     state;
    logic [7:0] m_q;
    logic [7:0] p_q;
    logic [7:0] q_q;
    logic [2:0] cnt;
`ifdef ALU_MUL_SKIP_EN
    // SHR must know whether the ALU holds a fresh sum or nothing useful
    logic       added;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            m_q   <= '0;
            p_q   <= '0;
            q_q   <= '0;
            cnt   <= '0;
            prod  <= '0;
            done  <= 1'b0;
`ifdef ALU_MUL_SKIP_EN
            added <= 1'b0;
`endif
        end else if (RDY) begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        m_q <= a_in;
                        q_q <= b_in;
                        p_q <= '0;
                        cnt <= '0;
`ifdef ALU_MUL_SKIP_EN
                        added <= 1'b0;
                        state <= b_in[0] ? S_ADD : S_SHR;
`else
                        state <= S_ADD;
`endif
                    end
                end
                S_ADD: begin
`ifdef ALU_MUL_SKIP_EN
                    added <= 1'b1;
`endif
                    state <= S_SHR;
                end
                S_SHR: state <= S_CAP;
                S_CAP: begin
                    p_q <= alu_out;
                    q_q <= {alu_co, q_q[7:1]};
                    cnt <= cnt + 3'd1;
`ifdef ALU_MUL_SKIP_EN
                    added <= 1'b0;
                    // q_q[1] becomes the next Q[0] after this shift
                    if (cnt == 3'd7)   state <= S_DONE;
                    else if (q_q[1])   state <= S_ADD;
                    else               state <= S_SHR;
`else
                    state <= (cnt == 3'd7) ? S_DONE : S_ADD;
`endif
                end
                S_DONE: begin
                    prod  <= {p_q, q_q};
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // ALU drive decodes from state; SHR feeds the registered sum back for the shift
    always_comb begin
        alu_op    = 4'b1111;
        alu_right = 1'b0;
        alu_ai    = 8'h00;
        alu_bi    = 8'h00;
        alu_ci    = 1'b0;
        case (state)
            S_ADD: begin
                alu_op = 4'b0011;
                alu_ai = p_q;
                alu_bi = q_q[0] ? m_q : 8'h00;
            end
            S_SHR: begin
                alu_right = 1'b1;
`ifdef ALU_MUL_SKIP_EN
                alu_ai = added ? alu_out : p_q;
                alu_ci = added ? alu_co  : 1'b0;
`else
                alu_ai = alu_out;
                alu_ci = alu_co;
`endif
            end
            default: ;
        endcase
    end

    assign alu_bcd = 1'b0;
    assign busy    = (state == S_ADD) || (state == S_SHR) || (state == S_CAP);

endmodule

// File: doc/alu_mul_seq.md
ALU_MUL_SEQ -- requirements
Module: alu_mul_seq

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset: clk and rst_n.
REQ-002 SHALL provide ports as below (name  direction  width  meaning):
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- RDY  in  1  global advance enable; low freezes all state except reset
- start  in  1  request an 8x8 unsigned multiply
- a_in  in  8  multiplicand
- b_in  in  8  multiplier
- busy  out  1  sequence in progress; also the ALU ownership grant to the external ALU input mux
- done  out  1  one-cycle completion pulse
- prod  out  16  product, held until the next accepted start
- alu_op  out  4  ALU op code
- alu_right  out  1  ALU right-shift select
- alu_ai  out  8  ALU AI operand
- alu_bi  out  8  ALU BI operand
- alu_ci  out  1  ALU carry in
- alu_bcd  out  1  ALU BCD select, constant 0
- alu_out  in  8  registered ALU result, valid the RDY cycle after issue
- alu_co  in  1  registered ALU carry out, same timing as alu_out

Function
REQ-003 SHALL accept start only in IDLE with RDY=1, latching a_in to M, b_in to Q, clearing P (8 bits) and the bit counter; start in any other state SHALL be ignored.
REQ-004 SHALL use the states IDLE -> ADD -> SHR -> CAP, repeating ADD -> SHR -> CAP eight times, then DONE -> IDLE.
REQ-005 ADD SHALL drive alu_op=0011, alu_right=0, alu_ai=P, alu_bi=(Q[0] ? M : 8'h00), alu_ci=0.
REQ-006 SHR SHALL drive alu_op=1111, alu_right=1, alu_ai=alu_out, alu_ci=alu_co, alu_bi=8'h00, so that the ALU returns {carry, sum[7:1]} with CO=sum[0].
REQ-007 CAP SHALL load P<=alu_out and Q<={alu_co, Q[7:1]}, then increment the counter; after the 8th CAP it SHALL go to DONE.
REQ-008 DONE SHALL assert done=1 for exactly one RDY-qualified cycle, load prod<={P,Q}, and return to IDLE.
REQ-009 In IDLE and DONE the block SHALL drive alu_op=1111, alu_right=0, alu_ai=0, alu_bi=0, alu_ci=0; alu_bcd SHALL always be 0.
REQ-010 busy SHALL be 1 in ADD, SHR and CAP, and 0 in IDLE and DONE.
REQ-011 Latency: with start sampled at edge k, done SHALL be high during cycle k+25 (RDY held high throughout).
REQ-012 RDY=0 SHALL hold the state, counter, P, Q, M, prod and done; the ALU drive SHALL stay stable, and done SHALL remain high while RDY is low if it was high.
REQ-013 Changes to a_in and b_in after start is accepted SHALL NOT affect the result.
REQ-014 Results SHALL be exact for all 65536 operand pairs (max 0xFF*0xFF=0xFE01).

Reset
REQ-015 rst_n=0 at a clock edge SHALL force IDLE and clear counter, P, Q, M, prod, busy and done, regardless of RDY.
REQ-016 Reset mid-sequence SHALL abort with no done pulse, and prod SHALL read 0.

Configuration
REQ-017 Macro ALU_MUL_SKIP_EN: when defined, SHALL go CAP -> SHR (and IDLE -> SHR) whenever the next Q[0]=0, skipping ADD; in that case SHR SHALL drive alu_ai=P and alu_ci=0. done SHALL then be high in cycle k+17+popcount(b_in).
REQ-018 Without ALU_MUL_SKIP_EN, ADD SHALL always execute and latency SHALL be fixed per REQ-011.

Verification
REQ-019 a=0x0F, b=0x11 -> prod=0x00FF, done at k+25, busy high for 24 cycles.
REQ-020 a=0xFF, b=0xFF -> prod=0xFE01 (exercises carry into the shift); a=0x00, b=0xA5 -> prod=0x0000.
REQ-021 a=0x12, b=0x34 with RDY low for 5 cycles mid-sequence -> prod=0x03A8, done at k+30, no glitch on the ALU drive.
REQ-022 Pulse start again and change a_in/b_in while busy -> ignored, first result intact; rst_n low at k+10 -> busy=0, prod=0, no done.
REQ-023 With ALU_MUL_SKIP_EN: b=0x01 -> done at k+18; b=0x00 -> done at k+17; b=0xFF -> done at k+25; products are the same as without the macro.
